// File: rtl/cam_pkg.sv
// Shared types and sizing for the CAM tag resolution path.
package cam_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int CAM_NUM_CELLS = 100;

    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tag_priority_encoder.sv
// Lowest-set-bit search over the tag snapshot; idx is 0 when nothing is set.
module tag_priority_encoder
    import cam_pkg::*;
#(
    parameter  int num_cells = CAM_NUM_CELLS,
    localparam int idx_bits  = idx_width(num_cells)
) (
    input  logic [num_cells-1:0] vec,
    output logic [idx_bits-1:0]  idx,
    output logic                 found
);

    // Walk high to low so the last hit written is the lowest index.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = num_cells - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx   = idx_bits'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tag_resolver.sv
// Snapshots CAM match tags and streams matching indices lowest-first over a valid/ready port.
// Optional match_count output enabled by defining TAG_RESOLVER_MATCH_COUNT_EN.
module tag_resolver
    import cam_pkg::*;
#(
    parameter  int num_cells = CAM_NUM_CELLS,
    localparam int idx_bits  = idx_width(num_cells),
    localparam int cnt_bits  = $clog2(num_cells + 1)
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [num_cells-1:0] tag_wires,
    input  logic                 capture,
    input  logic                 flush,
    input  logic                 match_ready,
    output logic                 match_valid,
    output logic [idx_bits-1:0]  match_idx,
    output logic                 any_match,
    output logic                 busy,
    output logic                 done
`ifdef TAG_RESOLVER_MATCH_COUNT_EN
    ,
    output logic [cnt_bits-1:0]  match_count
`endif
);

    state_t               state, state_nx;
    logic [num_cells-1:0] snapshot, snapshot_nx;
    logic                 cap_en;
    logic [idx_bits-1:0]  enc_idx;
    logic                 enc_found;

    tag_priority_encoder #(.num_cells(num_cells)) u_enc (
        .vec   (snapshot),
        .idx   (enc_idx),
        .found (enc_found)
    );

    always_comb begin
        state_nx    = state;
        snapshot_nx = snapshot;
        cap_en      = 1'b0;
        case (state)
            IDLE: begin
                // flush alongside capture drops the capture
                if (capture && !flush) begin
                    cap_en      = 1'b1;
                    snapshot_nx = tag_wires;
                    state_nx    = (|tag_wires) ? SCAN : DONE;
                end
            end
            SCAN: begin
                if (flush) begin
                    snapshot_nx = '0;
                    state_nx    = DONE;
                end else if (match_ready) begin
                    // x & (x-1) retires exactly the bit the encoder is presenting
                    snapshot_nx = snapshot & (snapshot - num_cells'(1));
                    if (snapshot_nx == '0)
                        state_nx = DONE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            snapshot  <= '0;
            any_match <= 1'b0;
        end else begin
            state    <= state_nx;
            snapshot <= snapshot_nx;
            if (cap_en)
                any_match <= |tag_wires;
        end
    end

    // Outputs decode straight from state so an async reset clears them immediately.
    assign match_valid = (state == SCAN) && enc_found;
    assign match_idx   = match_valid ? enc_idx : '0;
    assign busy        = (state != IDLE);
    assign done        = (state == DONE);

`ifdef TAG_RESOLVER_MATCH_COUNT_EN
    logic [cnt_bits-1:0] pop;

    always_comb begin
        pop = '0;
        for (int i = 0; i < num_cells; i++)
            pop = pop + cnt_bits'(tag_wires[i]);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            match_count <= '0;
        else if (cap_en)
            match_count <= pop;
    end
`endif

endmodule
